// File: rtl/bit_stuffer_tx.sv
// -----------------------------------------------------------------------------
// bit_stuffer_tx
//
// Serialises packet bytes LSB first onto a single line and inserts a 0 after
// every run of six consecutive 1s. The run counter carries across byte
// boundaries inside a packet. A one-byte holding register lets the next byte
// be queued while the current one shifts out, so consecutive bytes leave
// with no gap bit time.
//
// Optional build macro:
//   NRZI_ENCODE_EN  defined   -> tx_bit is NRZI-coded: a 0 in the stuffed
//                                stream toggles the line, a 1 holds it.
//                                The line idles and returns to 1.
//                   undefined -> tx_bit carries the raw stuffed stream.
//
// Ports:
//   clk            in   single clock
//   rst            in   synchronous, active-high reset
//   byte_in[7:0]   in   packet byte
//   byte_valid     in   byte_in / byte_last valid
//   byte_last      in   byte_in is the final byte of the packet
//   byte_ready     out  byte accepted on byte_valid && byte_ready
//   tx_bit_en      in   one-cycle bit-time strobe
//   tx_bit         out  serial line bit (idle level 1)
//   tx_bit_valid   out  one-cycle pulse: tx_bit updated this cycle
//   stuff_inserted out  pulses with tx_bit_valid when the bit is a stuffed 0
//   tx_done        out  one-cycle pulse after the final bit of a packet
//   underrun_err   out  one-cycle pulse when a packet is aborted for lack of data
//   busy           out  high in any state other than IDLE
//
// Handshake: byte_valid/byte_last/byte_in are held stable by the source until
// the cycle where byte_valid && byte_ready is seen at a rising clk edge; that
// edge transfers the byte. byte_ready never depends combinationally on
// byte_valid. After a byte with byte_last is accepted, byte_ready stays low
// until the packet has finished (tx_done).
// -----------------------------------------------------------------------------
module bit_stuffer_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       tx_bit_en,
    output logic       tx_bit,
    output logic       tx_bit_valid,
    output logic       stuff_inserted,
    output logic       tx_done,
    output logic       underrun_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state;

    // Shift register and the byte currently being serialised.
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       cur_last;
    logic [2:0] ones_cnt;
    // Set once the final data bit has gone out, so STUFF knows to finish.
    logic       data_done;

    // Holding register for the next byte.
    logic [7:0] hold_byte;
    logic       hold_last;
    logic       hold_full;
    // A last byte has been accepted; no more bytes until the packet ends.
    logic       pkt_closed;

    logic       accept;
    logic       data_bit;
    logic       byte_end;
    logic       stuff_req;
    logic       bypass;
    logic       hold_load;
    logic       hold_full_n;
    logic       pkt_closed_n;
    logic       data_line;
    logic       stuff_line;

    always_comb begin
        accept    = byte_valid && byte_ready;
        data_bit  = shift_reg[0];
        byte_end  = (state == SHIFT) && tx_bit_en && (bit_idx == 3'd7);
        // The sixth consecutive 1 is the one being emitted now.
        stuff_req = data_bit && (ones_cnt == 3'd5);
        // A byte arriving exactly as the shift register empties goes straight
        // into the shift register instead of through the holding register.
        bypass    = byte_end && !hold_full && accept;
        hold_load = accept && (state != IDLE) && !bypass;

        hold_full_n = hold_full;
        if (byte_end && hold_full) begin
            hold_full_n = 1'b0;
        end else if (hold_load) begin
            hold_full_n = 1'b1;
        end

        pkt_closed_n = pkt_closed;
        if (accept && byte_last) begin
            pkt_closed_n = 1'b1;
        end else if (state == DONE) begin
            pkt_closed_n = 1'b0;
        end

`ifdef NRZI_ENCODE_EN
        data_line  = data_bit ? tx_bit : ~tx_bit;
        stuff_line = ~tx_bit;
`else
        data_line  = data_bit;
        stuff_line = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shift_reg      <= 8'h00;
            bit_idx        <= 3'd0;
            cur_last       <= 1'b0;
            ones_cnt       <= 3'd0;
            data_done      <= 1'b0;
            hold_byte      <= 8'h00;
            hold_last      <= 1'b0;
            hold_full      <= 1'b0;
            pkt_closed     <= 1'b0;
            byte_ready     <= 1'b1;
            tx_bit         <= 1'b1;
            tx_bit_valid   <= 1'b0;
            stuff_inserted <= 1'b0;
            tx_done        <= 1'b0;
            underrun_err   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            hold_full      <= hold_full_n;
            pkt_closed     <= pkt_closed_n;
            byte_ready     <= !hold_full_n && !pkt_closed_n;
            tx_bit_valid   <= 1'b0;
            stuff_inserted <= 1'b0;
            tx_done        <= 1'b0;
            underrun_err   <= 1'b0;

            if (hold_load) begin
                hold_byte <= byte_in;
                hold_last <= byte_last;
            end

            case (state)
                IDLE: begin
                    tx_bit <= 1'b1;
                    if (accept) begin
                        shift_reg <= byte_in;
                        cur_last  <= byte_last;
                        bit_idx   <= 3'd0;
                        ones_cnt  <= 3'd0;
                        data_done <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (tx_bit_en) begin
                        tx_bit       <= data_line;
                        tx_bit_valid <= 1'b1;
                        ones_cnt     <= data_bit ? ones_cnt + 3'd1 : 3'd0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_idx      <= bit_idx + 3'd1;
                        state        <= stuff_req ? STUFF : SHIFT;
                        if (bit_idx == 3'd7) begin
                            if (hold_full) begin
                                shift_reg <= hold_byte;
                                cur_last  <= hold_last;
                            end else if (accept) begin
                                shift_reg <= byte_in;
                                cur_last  <= byte_last;
                            end else if (cur_last) begin
                                data_done <= 1'b1;
                                if (!stuff_req) begin
                                    state <= DONE;
                                end
                            end else begin
                                // Starved mid-packet: abort and drop it.
                                underrun_err <= 1'b1;
                                ones_cnt     <= 3'd0;
                                busy         <= 1'b0;
                                state        <= IDLE;
                            end
                        end
                    end
                end

                STUFF: begin
                    if (tx_bit_en) begin
                        tx_bit         <= stuff_line;
                        tx_bit_valid   <= 1'b1;
                        stuff_inserted <= 1'b1;
                        ones_cnt       <= 3'd0;
                        state          <= data_done ? DONE : SHIFT;
                    end
                end

                DONE: begin
                    tx_done   <= 1'b1;
                    tx_bit    <= 1'b1;
                    ones_cnt  <= 3'd0;
                    data_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stuffer_tx.sv
// -----------------------------------------------------------------------------
// tb_bit_stuffer_tx
//
// Directed bench for bit_stuffer_tx. A table of packet records (bytes, strobe
// period, expected stuffed bit stream, expected stuff positions, expected
// tx_done / underrun counts) is applied in a loop; hand-written sequences
// cover reset values, strobes while idle, and reset in the middle of a byte.
// Bit i of exp_bits / exp_stuff is the i-th bit emitted on the line.
// -----------------------------------------------------------------------------
module tb_bit_stuffer_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       tx_bit_en;
    logic       tx_bit;
    logic       tx_bit_valid;
    logic       stuff_inserted;
    logic       tx_done;
    logic       underrun_err;
    logic       busy;

    always #5 clk = ~clk;

    bit_stuffer_tx dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_last      (byte_last),
        .byte_ready     (byte_ready),
        .tx_bit_en      (tx_bit_en),
        .tx_bit         (tx_bit),
        .tx_bit_valid   (tx_bit_valid),
        .stuff_inserted (stuff_inserted),
        .tx_done        (tx_done),
        .underrun_err   (underrun_err),
        .busy           (busy)
    );

    typedef struct {
        logic [7:0]  b0;
        logic        l0;
        int          nb;
        logic [7:0]  b1;
        logic        l1;
        int          period;
        int          exp_n;
        logic [31:0] exp_bits;
        logic [31:0] exp_stuff;
        int          exp_done;
        int          exp_under;
        logic        exp_gapless;
    } vec_t;

    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

`ifdef NRZI_ENCODE_EN
    function automatic logic [31:0] nrzi_model(input logic [31:0] raw, input int n);
        logic        l = 1'b1;
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) begin
            if (!raw[i]) l = ~l;
            r[i] = l;
        end
        return r;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input vec_t v, input string tag);
        int          n = 0, sent = 0, ndone = 0, nunder = 0, cyc = 0, tail = -1;
        int          first_v = -1, last_v = -1, done_cyc = -1;
        int          ready_viol = 0, stall = 0, stray = 0;
        logic [31:0] bits = '0, stuff = '0;
        logic        last_acc = 1'b0, fire, raw;
`ifdef NRZI_ENCODE_EN
        logic [31:0] line = '0;
        logic        prev = 1'b1;
`endif
        while (cyc < 400 && (tail < 0 || cyc < tail)) begin
            byte_valid = (sent < v.nb);
            byte_in    = (sent == 0) ? v.b0 : v.b1;
            byte_last  = (sent == 0) ? v.l0 : v.l1;
            tx_bit_en  = ((cyc % v.period) == (v.period - 1));
            fire       = byte_valid && byte_ready;
            if (byte_valid && !byte_ready) stall++;
            tick();
            cyc++;
            if (fire) begin
                sent++;
                if (byte_last) last_acc = 1'b1;
            end
            if (tx_bit_valid) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
`ifdef NRZI_ENCODE_EN
                raw  = (tx_bit == prev);
                prev = tx_bit;
                if (n < 32) line[n] = tx_bit;
`else
                raw = tx_bit;
`endif
                if (n < 32) begin
                    bits[n]  = raw;
                    stuff[n] = stuff_inserted;
                end
                n++;
            end else if (stuff_inserted) begin
                stray++;
            end
            if (tx_done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (underrun_err) nunder++;
            if (last_acc && ndone == 0 && byte_ready) ready_viol++;
            if ((tx_done || underrun_err) && tail < 0) tail = cyc + 3;
        end
        byte_valid = 1'b0;
        tx_bit_en  = 1'b0;

        check({tag, "_terminated"}, (tail >= 0), 1);
        check({tag, "_nbits"}, n, v.exp_n);
        check({tag, "_bits"}, bits, v.exp_bits);
        check({tag, "_stuff_pos"}, stuff, v.exp_stuff);
        check({tag, "_stray_stuff"}, stray, 0);
        check({tag, "_done_cnt"}, ndone, v.exp_done);
        check({tag, "_underrun_cnt"}, nunder, v.exp_under);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_idle_line"}, tx_bit, 1);
        check({tag, "_ready_after"}, byte_ready, 1);
        check({tag, "_ready_low_after_last"}, ready_viol, 0);
`ifdef NRZI_ENCODE_EN
        check({tag, "_nrzi_line"}, line, nrzi_model(v.exp_bits, v.exp_n));
`endif
        if (v.exp_done > 0) check({tag, "_done_follows_last_bit"}, done_cyc, last_v + 1);
        if (v.exp_gapless) begin
            check({tag, "_no_gap"}, last_v - first_v + 1, n);
            check({tag, "_never_blocked"}, stall, 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1);
        check({tag, "_tx_bit"}, tx_bit, 1);
        check({tag, "_tx_bit_valid"}, tx_bit_valid, 0);
        check({tag, "_stuff_inserted"}, stuff_inserted, 0);
        check({tag, "_tx_done"}, tx_done, 0);
        check({tag, "_underrun_err"}, underrun_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic idle_strobes();
        int bad = 0;
        byte_valid = 1'b0;
        tx_bit_en  = 1'b1;
        repeat (6) begin
            tick();
            if (tx_bit_valid || busy || tx_bit !== 1'b1 || stuff_inserted) bad++;
        end
        tx_bit_en = 1'b0;
        check("idle_strobes_ignored", bad, 0);
    endtask

    task automatic reset_mid_packet();
        int   seen = 0, cyc = 0;
        logic fire;
        byte_in    = 8'hFF;
        byte_last  = 1'b1;
        byte_valid = 1'b1;
        tx_bit_en  = 1'b1;
        while (seen < 4 && cyc < 50) begin
            fire = byte_valid && byte_ready;
            tick();
            cyc++;
            if (fire) byte_valid = 1'b0;
            if (tx_bit_valid) seen++;
        end
        byte_valid = 1'b0;
        check("rst_mid_reached_bit4", seen, 4);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        tx_bit_en = 1'b0;
        check_reset_values("rst_mid");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        tx_bit_en  = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // b0 l0 nb b1 l1 period n bits stuff done under gapless
        vecs[0] = '{8'hFF, 1'b1, 1, 8'h00, 1'b0, 1, 9,  32'h0000_01BF, 32'h0000_0040, 1, 0, 1'b1};
        vecs[1] = '{8'hFC, 1'b1, 1, 8'h00, 1'b0, 2, 9,  32'h0000_00FC, 32'h0000_0100, 1, 0, 1'b0};
        vecs[2] = '{8'hE0, 1'b0, 2, 8'h07, 1'b1, 1, 17, 32'h0000_07E0, 32'h0000_0800, 1, 0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1, 8'h00, 1'b0, 1, 8,  32'h0000_0055, 32'h0000_0000, 0, 1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1, 8'h00, 1'b0, 1, 8,  32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1};
        vecs[5] = '{8'hA5, 1'b0, 2, 8'h3C, 1'b1, 3, 16, 32'h0000_3CA5, 32'h0000_0000, 1, 0, 1'b0};
        vecs[6] = '{8'hFE, 1'b0, 2, 8'h03, 1'b1, 2, 17, 32'h0000_077E, 32'h0000_0080, 1, 0, 1'b0};
        vecs[7] = '{8'hFC, 1'b0, 2, 8'h01, 1'b1, 1, 17, 32'h0000_02FC, 32'h0000_0100, 1, 0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            run_packet(vecs[i], $sformatf("vec%0d", i));
        end

        idle_strobes();
        reset_mid_packet();
        run_packet(vecs[4], "after_rst_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_stuffer_tx.md
BIT_STUFFER_TX -- requirements
Module: bit_stuffer_tx

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port byte_in, input, 8, packet byte, serialized LSB first.
REQ-004 SHALL have port byte_valid, input, 1, byte_in and byte_last valid.
REQ-005 SHALL have port byte_last, input, 1, marks final byte of the packet.
REQ-006 SHALL have port byte_ready, output, 1, block accepts byte when byte_valid && byte_ready.
REQ-007 SHALL have port tx_bit_en, input, 1, one-cycle bit-time strobe (12 MHz rate).
REQ-008 SHALL have port tx_bit, output, 1, serial line bit.
REQ-009 SHALL have port tx_bit_valid, output, 1, one-cycle pulse, tx_bit updated this cycle.
REQ-010 SHALL have port stuff_inserted, output, 1, pulse with tx_bit_valid when emitted bit is a stuffed 0.
REQ-011 SHALL have port tx_done, output, 1, one-cycle pulse after final packet bit (incl. trailing stuff bit).
REQ-012 SHALL have port underrun_err, output, 1, one-cycle pulse on starvation abort.
REQ-013 SHALL have port busy, output, 1, high in any state but IDLE.

Function
REQ-014 SHALL implement states IDLE, SHIFT, STUFF, DONE.
REQ-015 SHALL hold one shift register (8 b + 3 b bit index) plus one holding register (byte, last flag, full flag); byte_ready = !holding_full.
REQ-016 IDLE: accepted byte SHALL load into the shift register directly, clear the ones counter, go to SHIFT next cycle; first bit no earlier than the first tx_bit_en after acceptance.
REQ-017 SHIFT, on tx_bit_en: SHALL emit shift_reg[0], pulse tx_bit_valid, advance bit index; ones counter +1 on data 1, cleared on data 0.
REQ-018 If the emitted data bit is 1 and the counter reaches 6, next state SHALL be STUFF, regardless of byte boundary or last flag.
REQ-019 STUFF, on tx_bit_en: SHALL emit 0, pulse stuff_inserted, clear counter, then resume SHIFT, or go to DONE if the last data bit already went out.
REQ-020 Ones counter SHALL persist across byte boundaries within a packet.
REQ-021 On bit index 7 emission: holding full -> move to shift register same cycle (no gap bit time); holding empty and current byte last -> DONE (or STUFF first, per REQ-018); holding empty and not last -> pulse underrun_err, go IDLE, drop packet.
REQ-022 Holding register SHALL accept a byte in the same cycle it is emptied (simultaneous load/unload), no byte lost or duplicated.
REQ-023 Bytes SHALL NOT be accepted after a last byte until DONE completes (byte_ready low).
REQ-024 DONE: SHALL pulse tx_done for one cycle, go IDLE next cycle.
REQ-025 tx_bit_en outside SHIFT/STUFF SHALL be ignored; tx_bit holds idle level (1) when not transmitting.
REQ-026 All outputs SHALL be registered; tx_bit changes only in tx_bit_valid cycles.

Reset
REQ-027 rst SHALL override all activity in any state, including mid-byte and mid-STUFF; the packet is discarded.
REQ-028 Reset values: state IDLE, byte_ready 1 (first cycle after reset), tx_bit 1, tx_bit_valid 0, stuff_inserted 0, tx_done 0, underrun_err 0, busy 0, ones counter 0, holding empty.

Configuration
REQ-029 Macro NRZI_ENCODE_EN defined: tx_bit SHALL be NRZI-encoded (stuffed stream 0 toggles line, 1 holds); line register resets to 1 and returns to 1 in DONE.
REQ-030 Macro NRZI_ENCODE_EN undefined: tx_bit SHALL be the raw stuffed bit stream; all other behaviour identical.

Verification
REQ-031 Single last byte 0xFF -> bits 1,1,1,1,1,1,0s,1,1 (9 bits), stuff_inserted once at bit 7, tx_done once.
REQ-032 Single last byte 0xFC -> 0,0,1,1,1,1,1,1,0s (9 bits), trailing stuff before tx_done.
REQ-033 Bytes 0xE0,0x07(last), tx_bit_en every cycle -> 17 bits, stuff after bit 11, no gap between bytes, byte_ready never blocks.
REQ-034 Byte 0x55 not last, no second byte -> 8 bits then underrun_err pulse, busy 0, no tx_done.
REQ-035 rst asserted at bit 4 of 0xFF -> next cycle all outputs at reset values; following 0x00 last packet sends 8 zeros, no stuff.
REQ-036 NRZI_ENCODE_EN defined, byte 0x00 last -> tx_bit 0,1,0,1,0,1,0,1, then tx_bit 1 after DONE.
